// File: rtl/air_quality_pkg.sv
// Shared types and constants for the air-quality input filter.
// Holds the FSM state encoding and the output-width defaults.
package air_quality_pkg;

    typedef enum logic [1:0] {
        WARMUP,
        RUN,
        FAULT
    } aq_state_e;

    localparam int AQ_W            = 8;
    localparam int SPIKE_LIMIT_DEF = 40;

endpackage

// File: rtl/aq_sample_buffer.sv
// Circular sample store for the moving-average window.
// Exposes the entry about to be overwritten as the oldest sample.
module aq_sample_buffer #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] oldest
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;

    // A clear may carry a write: that sample lands in slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (we && i == 0) ? wdata : '0;
            end
            wptr <= we ? ADDR_W'(1) : '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
        end
    end

    assign oldest = mem[wptr];

endmodule

// File: rtl/air_quality_filter.sv
// Moving-average front end for the air-quality monitor, with watchdog.
// Optional spike rejection is built when AQ_FILTER_SPIKE_REJECT_EN is defined.
module air_quality_filter
    import air_quality_pkg::*;
#(
    parameter int SAMPLE_W       = 10,
    parameter int AVG_LOG2       = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SPIKE_LIMIT    = SPIKE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] raw_sample,
    input  logic                raw_valid,
    output logic                raw_ready,
    output logic [AQ_W-1:0]     air_quality,
    output logic                aq_valid,
    output logic                sensor_fault
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = SAMPLE_W + AVG_LOG2;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    aq_state_e state, state_nxt;

    logic [SUM_W-1:0]    sum, sum_nxt, sum_upd;
    logic [AVG_LOG2-1:0] fill, fill_nxt;
    logic [WD_W-1:0]     wd, wd_nxt, wd_inc;
    logic [AQ_W-1:0]     aq_nxt;
    logic                aqv_nxt;
    logic                fault_nxt;
    logic                buf_we;
    logic                buf_clr;
    logic [SAMPLE_W-1:0] oldest;
    logic                accept;
    logic                take;

    assign accept  = raw_valid & raw_ready;
    assign sum_upd = sum + SUM_W'(raw_sample) - SUM_W'(oldest);
    assign wd_inc  = wd + 1'b1;

    aq_sample_buffer #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (AVG_LOG2)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .we     (buf_we),
        .wdata  (raw_sample),
        .oldest (oldest)
    );

`ifdef AQ_FILTER_SPIKE_REJECT_EN
    logic [1:0]      rej_cnt;
    logic [AQ_W-1:0] s8;
    logic [AQ_W-1:0] diff;
    logic            spike;

    assign s8    = raw_sample[SAMPLE_W-1 -: AQ_W];
    assign diff  = (s8 > air_quality) ? s8 - air_quality
                                      : air_quality - s8;
    assign spike = int'(diff) > SPIKE_LIMIT;
    // After three straight rejections the next sample is forced in.
    assign take  = !spike || (rej_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rej_cnt <= '0;
        end else if (accept) begin
            if (state == RUN && !take) begin
                rej_cnt <= rej_cnt + 1'b1;
            end else begin
                rej_cnt <= '0;
            end
        end
    end
`else
    logic unused_spike_cfg;

    assign unused_spike_cfg = ^SPIKE_LIMIT;
    assign take             = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WARMUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        fill_nxt  = fill;
        wd_nxt    = wd;
        aq_nxt    = air_quality;
        aqv_nxt   = 1'b0;
        fault_nxt = sensor_fault;
        buf_we    = 1'b0;
        buf_clr   = 1'b0;
        unique case (state)
            WARMUP: begin
                if (accept) begin
                    wd_nxt   = '0;
                    buf_we   = 1'b1;
                    sum_nxt  = sum_upd;
                    fill_nxt = fill + 1'b1;
                    if (fill == AVG_LOG2'(DEPTH - 1)) begin
                        state_nxt = RUN;
                        aq_nxt    = sum_upd[SUM_W-1 -: AQ_W];
                        aqv_nxt   = 1'b1;
                    end
                end else begin
                    wd_nxt = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    wd_nxt = '0;
                    if (take) begin
                        buf_we  = 1'b1;
                        sum_nxt = sum_upd;
                        aq_nxt  = sum_upd[SUM_W-1 -: AQ_W];
                        aqv_nxt = 1'b1;
                    end
                end else begin
                    wd_nxt = wd_inc;
                    if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                    end
                end
            end
            FAULT: begin
                // Recovery sample becomes fill sample 1 of a fresh window.
                if (accept) begin
                    state_nxt = WARMUP;
                    fault_nxt = 1'b0;
                    wd_nxt    = '0;
                    buf_clr   = 1'b1;
                    buf_we    = 1'b1;
                    sum_nxt   = SUM_W'(raw_sample);
                    fill_nxt  = AVG_LOG2'(1);
                end
            end
            default: begin
                state_nxt = WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum          <= '0;
            fill         <= '0;
            wd           <= '0;
            air_quality  <= '0;
            aq_valid     <= 1'b0;
            sensor_fault <= 1'b0;
            raw_ready    <= 1'b0;
        end else begin
            sum          <= sum_nxt;
            fill         <= fill_nxt;
            wd           <= wd_nxt;
            air_quality  <= aq_nxt;
            aq_valid     <= aqv_nxt;
            sensor_fault <= fault_nxt;
            raw_ready    <= 1'b1;
        end
    end

endmodule
